// File: rtl/prefetch_unit_if.sv
// Memory fetch handshake between the prefetch unit (master) and the bus/memory side (slave).
interface prefetch_unit_if #(
   parameter int ADDR_W    = 20,
   parameter int BUS_BYTES = 1
);
   logic                   mem_req;
   logic [ADDR_W-1:0]      mem_addr;
   logic                   mem_ack;
   logic [8*BUS_BYTES-1:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: fetches code bytes at CS:IP into a circular byte buffer and
// presents the oldest bytes to the decoder, with variable-length consume and flush-on-jump.
module prefetch_unit #(
   parameter  int DEPTH     = 6,
   parameter  int BUS_BYTES = 1,
   parameter  int OUT_BYTES = 4,
   parameter  int ADDR_W    = 20,
   localparam int CNT_W     = $clog2(DEPTH + 1),
   localparam int CN_W      = $clog2(OUT_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            cs_i,
   input  logic                   ip_load_i,
   input  logic [15:0]            ip_new_i,
   prefetch_unit_if.master        mem,
   output logic [8*OUT_BYTES-1:0] instr_o,
   output logic [CNT_W-1:0]       count_o,
   input  logic [CN_W-1:0]        consume_n_i,
   output logic [15:0]            head_ip_o,
   output logic                   consume_err_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

   // Pointer advance modulo DEPTH; n never exceeds DEPTH so one correction suffices.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int n);
      int s;
      s = int'(ptr) + n;
      s = (s >= DEPTH) ? s - DEPTH : s;
      return PTR_W'(s);
   endfunction

   logic [7:0]        buf_q [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q, head_d, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [15:0]       fetch_ip_q, fetch_ip_d, head_ip_q, head_ip_d;
   logic              consume_err_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   state_e            state_q;

   logic              consume_ok_s, push_s, can_fetch_s;
   int                pop_n_s;
   logic [ADDR_W-1:0] fetch_addr_s;

   // Next-state for queue pointers, occupancy and IPs; a flush overrides push and consume.
   always_comb begin
      consume_ok_s = int'(consume_n_i) <= int'(count_q);
      push_s       = (state_q == ST_REQ) && mem.mem_ack && !ip_load_i;
      pop_n_s      = consume_ok_s ? int'(consume_n_i) : 0;
      can_fetch_s  = ((int'(count_q) + BUS_BYTES) <= DEPTH) && !ip_load_i;
      fetch_addr_s = ADDR_W'({8'h00, cs_i, 4'h0} + {12'h000, fetch_ip_q});
      if (ip_load_i) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         head_ip_d  = ip_new_i;
         fetch_ip_d = ip_new_i;
      end else begin
         head_d     = ptr_add(head_q, pop_n_s);
         tail_d     = push_s ? ptr_add(tail_q, BUS_BYTES) : tail_q;
         count_d    = CNT_W'(int'(count_q) - pop_n_s + (push_s ? BUS_BYTES : 0));
         head_ip_d  = head_ip_q + 16'(pop_n_s);
         fetch_ip_d = push_s ? fetch_ip_q + 16'(BUS_BYTES) : fetch_ip_q;
      end
   end

   // Decoder window: valid head bytes in order, zero beyond the current occupancy.
   always_comb begin
      instr_o = '0;
      for (int k = 0; k < OUT_BYTES; k++) begin
         if (k < int'(count_q)) begin
            instr_o[8*k +: 8] = buf_q[ptr_add(head_q, k)];
         end else begin
            instr_o[8*k +: 8] = 8'h00;
         end
      end
   end

   // Fetch FSM, buffer storage and all registered state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         fetch_ip_q    <= 16'h0000;
         head_ip_q     <= 16'h0000;
         consume_err_q <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         state_q       <= ST_IDLE;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         fetch_ip_q    <= fetch_ip_d;
         head_ip_q     <= head_ip_d;
         consume_err_q <= !ip_load_i && !consume_ok_s;
         if (push_s) begin
            for (int b = 0; b < BUS_BYTES; b++) buf_q[ptr_add(tail_q, b)] <= mem.mem_rdata[8*b +: 8];
         end
         case (state_q)
            ST_IDLE: begin
               if (can_fetch_s) begin
                  state_q    <= ST_REQ;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_addr_s;
               end else begin
                  mem_req_q  <= 1'b0;
               end
            end
            ST_REQ: begin
               // A jump without ack keeps the bus cycle alive but marks its data as stale.
               if (mem.mem_ack) begin
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
               end else if (ip_load_i) begin
                  state_q   <= ST_DISCARD;
               end else begin
                  state_q   <= ST_REQ;
               end
            end
            ST_DISCARD: begin
               if (mem.mem_ack) begin
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
               end else begin
                  state_q   <= ST_DISCARD;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_addr  = mem_addr_q;
   assign count_o       = count_q;
   assign head_ip_o     = head_ip_q;
   assign consume_err_o = consume_err_q;
endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios plus random traffic against a byte-queue reference model.
module tb_prefetch_unit;
   localparam int DEPTH     = 6;
   localparam int BUS_BYTES = 1;
   localparam int OUT_BYTES = 4;
   localparam int ADDR_W    = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cs = 16'h0000;
   logic        ip_load = 1'b0;
   logic [15:0] ip_new = 16'h0000;
   logic [2:0]  consume_n = 3'd0;
   logic [31:0] instr;
   logic [2:0]  count;
   logic [15:0] head_ip;
   logic        consume_err;

   int n_checks = 0;
   int n_errors = 0;

   prefetch_unit_if #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) mem ();

   prefetch_unit #(.DEPTH(DEPTH), .BUS_BYTES(BUS_BYTES), .OUT_BYTES(OUT_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .cs_i(cs), .ip_load_i(ip_load), .ip_new_i(ip_new), .mem(mem),
      .instr_o(instr), .count_o(count), .consume_n_i(consume_n), .head_ip_o(head_ip),
      .consume_err_o(consume_err)
   );

   always #5 clk = ~clk;

   // Reference model: byte queue plus an outstanding-fetch record.
   byte unsigned mq[$];
   logic [15:0]  m_head_ip, m_fetch_ip;
   logic [19:0]  m_addr;
   bit           m_busy, m_drop, m_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_head_ip  = 16'h0000;
      m_fetch_ip = 16'h0000;
      m_addr     = 20'h00000;
      m_busy     = 1'b0;
      m_drop     = 1'b0;
      m_err      = 1'b0;
   endtask

   task automatic check_all();
      logic [31:0] exp_instr;
      exp_instr = 32'h0;
      for (int k = 0; k < OUT_BYTES; k++)
         if (k < mq.size()) exp_instr[8*k +: 8] = mq[k];
      check_eq("mem_req", 64'(mem.mem_req), 64'(m_busy));
      if (m_busy) check_eq("mem_addr", 64'(mem.mem_addr), 64'(m_addr));
      check_eq("count", 64'(count), 64'(mq.size()));
      check_eq("instr", 64'(instr), 64'(exp_instr));
      check_eq("head_ip", 64'(head_ip), 64'(m_head_ip));
      check_eq("consume_err", 64'(consume_err), 64'(m_err));
   endtask

   // Drive one cycle of inputs and advance the model to what the DUT shows after the next edge.
   task automatic apply(input logic ld, input logic [15:0] nip, input int cn, input logic ack,
                        input logic [7:0] rd);
      int old_size;
      old_size      = mq.size();
      ip_load       = ld;
      ip_new        = nip;
      consume_n     = 3'(cn);
      mem.mem_ack   = ack;
      mem.mem_rdata = rd;
      m_err = !ld && (cn > old_size);
      if (!ld && cn <= old_size) begin
         for (int i = 0; i < cn; i++) void'(mq.pop_front());
         m_head_ip = 16'((int'(m_head_ip) + cn) % 65536);
      end
      if (m_busy && ack) begin
         if (!m_drop && !ld) begin
            mq.push_back(rd);
            m_fetch_ip = 16'((int'(m_fetch_ip) + BUS_BYTES) % 65536);
         end
         m_busy = 1'b0;
      end else if (m_busy && ld) begin
         m_drop = 1'b1;
      end else if (!m_busy && !ld && (DEPTH - old_size) >= BUS_BYTES) begin
         m_busy = 1'b1;
         m_drop = 1'b0;
         m_addr = 20'((int'(cs) * 16 + int'(m_fetch_ip)) % (1 << 20));
      end
      if (ld) begin
         mq.delete();
         m_fetch_ip = nip;
         m_head_ip  = nip;
      end
   endtask

   task automatic step(input logic ld, input logic [15:0] nip, input int cn, input logic ack,
                       input logic [7:0] rd);
      @(negedge clk);
      check_all();
      apply(ld, nip, cn, ack, rd);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 16 && !m_busy; i++) step(1'b0, 16'h0, 0, 1'b0, 8'h00);
      check_eq("req_timeout", 64'(m_busy), 64'(1));
   endtask

   task automatic fetch(input int dly, input logic [7:0] rd);
      wait_req();
      repeat (dly) step(1'b0, 16'h0, 0, 1'b0, 8'h00);
      step(1'b0, 16'h0, 0, 1'b1, rd);
   endtask

   initial begin
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_req", 64'(mem.mem_req), 64'(0));
      check_eq("rst_addr", 64'(mem.mem_addr), 64'(0));
      check_eq("rst_count", 64'(count), 64'(0));
      check_eq("rst_instr", 64'(instr), 64'(0));
      check_eq("rst_head_ip", 64'(head_ip), 64'(0));
      check_eq("rst_err", 64'(consume_err), 64'(0));

      // Jump to F000:FFF0 and fetch the reset vector bytes.
      rst = 1'b1;
      cs  = 16'hF000;
      apply(1'b1, 16'hFFF0, 0, 1'b0, 8'h00);
      wait_req();
      @(negedge clk);
      check_eq("first_addr", 64'(mem.mem_addr), 64'h0FFFF0);
      check_all();
      apply(1'b0, 16'h0, 0, 1'b1, 8'hEA);
      fetch(0, 8'h5B);
      fetch(0, 8'h00);
      fetch(0, 8'hE0);
      @(negedge clk);
      check_eq("vec_instr", 64'(instr), 64'hE0005BEA);
      check_eq("vec_count", 64'(count), 64'(4));
      check_all();
      apply(1'b0, 16'h0, 0, 1'b0, 8'h00);

      // Fill to capacity with slow acks, then confirm fetching stops.
      fetch(2, 8'h90);
      fetch(2, 8'h91);
      repeat (5) step(1'b0, 16'h0, 0, 1'b0, 8'h00);
      @(negedge clk);
      check_eq("full_count", 64'(count), 64'(6));
      check_eq("full_req", 64'(mem.mem_req), 64'(0));
      check_all();
      apply(1'b0, 16'h0, 2, 1'b0, 8'h00);
      wait_req();
      @(negedge clk);
      check_eq("refill_addr", 64'(mem.mem_addr), 64'h0FFFF6);
      check_all();
      apply(1'b0, 16'h0, 0, 1'b1, 8'h92);

      // Over-consume is rejected, then an exact consume empties the queue.
      step(1'b0, 16'h0, 2, 1'b0, 8'h00);
      step(1'b0, 16'h0, 4, 1'b0, 8'h00);
      @(negedge clk);
      check_eq("over_err", 64'(consume_err), 64'(1));
      check_eq("over_count", 64'(count), 64'(3));
      check_eq("over_head_ip", 64'(head_ip), 64'hFFF4);
      check_all();
      apply(1'b0, 16'h0, 3, 1'b0, 8'h00);
      @(negedge clk);
      check_eq("empty_count", 64'(count), 64'(0));
      check_eq("empty_instr", 64'(instr), 64'(0));
      check_all();
      apply(1'b0, 16'h0, 0, 1'b0, 8'h00);

      // Jump while a fetch is outstanding: the late data must be dropped.
      wait_req();
      step(1'b1, 16'h0100, 0, 1'b0, 8'h00);
      step(1'b0, 16'h0, 0, 1'b0, 8'h00);
      step(1'b0, 16'h0, 0, 1'b0, 8'h00);
      step(1'b0, 16'h0, 0, 1'b1, 8'hAA);
      @(negedge clk);
      check_eq("discard_count", 64'(count), 64'(0));
      check_all();
      apply(1'b0, 16'h0, 0, 1'b0, 8'h00);
      wait_req();
      @(negedge clk);
      check_eq("jump_addr", 64'(mem.mem_addr), 64'h0F0100);
      check_all();
      apply(1'b0, 16'h0, 0, 1'b1, 8'h11);

      // 20-bit address wrap and 16-bit fetch/head IP wrap.
      @(negedge clk);
      check_all();
      cs = 16'hFFFF;
      apply(1'b1, 16'hFFFF, 0, 1'b0, 8'h00);
      wait_req();
      @(negedge clk);
      check_eq("wrap_addr", 64'(mem.mem_addr), 64'h00FFEF);
      check_all();
      apply(1'b0, 16'h0, 0, 1'b1, 8'h33);
      wait_req();
      @(negedge clk);
      check_eq("ipwrap_addr", 64'(mem.mem_addr), 64'h0FFFF0);
      check_all();
      apply(1'b0, 16'h0, 1, 1'b0, 8'h00);
      @(negedge clk);
      check_eq("head_ip_wrap", 64'(head_ip), 64'h0000);
      check_all();
      apply(1'b0, 16'h0, 0, 1'b0, 8'h00);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic ld, ack;
         @(negedge clk);
         check_all();
         if ($urandom_range(0, 49) == 0) cs = 16'($urandom);
         ld  = ($urandom_range(0, 19) == 0);
         ack = m_busy ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
         apply(ld, 16'($urandom), int'($urandom_range(0, OUT_BYTES)), ack, 8'($urandom));
      end

      // Asynchronous reset mid-fetch with a nearly full queue.
      step(1'b1, 16'h2000, 0, 1'b0, 8'h00);
      for (int i = 0; i < 40 && mq.size() < 5; i++) fetch(0, 8'($urandom));
      wait_req();
      @(negedge clk);
      check_all();
      check_eq("pre_rst_count", 64'(count), 64'(5));
      #2 rst = 1'b0;
      #1;
      check_eq("arst_req", 64'(mem.mem_req), 64'(0));
      check_eq("arst_count", 64'(count), 64'(0));
      check_eq("arst_instr", 64'(instr), 64'(0));
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b1;
      cs  = 16'h1234;
      apply(1'b0, 16'h0, 0, 1'b0, 8'h00);
      fetch(1, 8'h5A);
      repeat (3) step(1'b0, 16'h0, 1, 1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Parametrised instruction prefetch queue with its own bus-fetch state machine. Successor to the fixed 4-byte queue in the bus interface unit.
- Forms the 20-bit fetch address from CS:IP and issues byte or word fetches over a req/ack memory handshake.
- Buffers up to DEPTH bytes and presents the oldest bytes to the decoder as a little-endian window.
- Supports variable-length consume and flush-on-jump.

Parameters:
- DEPTH, 6: queue capacity in bytes (≥ 2*BUS_BYTES).
- BUS_BYTES, 1: bytes returned per fetch (1 or 2).
- OUT_BYTES, 4: bytes presented on instr.
- ADDR_W, 20: physical address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  16  code segment value.
- ip_load  in  1  jump: flush queue, restart fetch at ip_new.
- ip_new  in  16  new IP for ip_load.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch physical address.
- mem_ack  in  1  data valid and fetch complete this cycle.
- mem_rdata  in  8*BUS_BYTES  fetched bytes; lowest byte is at mem_addr.
- instr  out  8*OUT_BYTES  head bytes; byte 0 is the oldest.
- count  out  clog2(DEPTH+1)  valid bytes in queue.
- consume_n  in  clog2(OUT_BYTES+1)  bytes removed this cycle (0 = none).
- head_ip  out  16  IP of queue byte 0.
- consume_err  out  1  one-cycle pulse when consume_n > count.

Behaviour:
- Reset (rst=0, async): queue empty, count=0, instr=0, mem_req=0, mem_addr=0, fetch_ip=0, head_ip=0, consume_err=0, FSM=IDLE.
- Address generation: mem_addr = ({cs,4'b0} + fetch_ip) mod 2^ADDR_W. fetch_ip wraps at 16 bits, 0xFFFF+1 → 0x0000.
- FSM states:
  - IDLE → REQ when free = DEPTH−count ≥ BUS_BYTES and ip_load=0. The free check uses the registered count before the same-cycle consume.
  - REQ: mem_req=1. mem_addr and mem_req stay stable until mem_ack. On mem_ack, push BUS_BYTES bytes, add BUS_BYTES to fetch_ip, go to IDLE. Back-to-back fetches therefore have one idle cycle between them.
  - DISCARD: entered when ip_load arrives while in REQ without mem_ack that cycle. mem_req stays 1 with the old address until mem_ack. The data is dropped, then → IDLE.
- mem_ack outside REQ/DISCARD is ignored.
- Latency: data pushed on an ack cycle is visible on count/instr the next cycle.
- Consume:
  - If consume_n ≤ count: remove consume_n head bytes and add consume_n to head_ip (16-bit wrap).
  - If consume_n > count: no removal, consume_err=1 for one cycle.
  - Push and consume in the same cycle both apply: count_next = count − consume_n + pushed.
- instr: byte k = queue byte k for k < count, otherwise 0x00. Combinational from queue state.
- Flush (ip_load=1):
  - Next cycle: count=0, fetch_ip=ip_new, head_ip=ip_new.
  - Overrides any same-cycle push and consume; no consume_err is generated.
  - If a same-cycle mem_ack lands in REQ, that data is dropped and the FSM goes to IDLE.
- Full: with free < BUS_BYTES, the FSM holds in IDLE and mem_req=0.
- Storage is a circular buffer with head/tail pointers mod DEPTH; DEPTH need not be a power of 2.

Test Plan:
- Reset, then cs=0xF000, ip_load with ip_new=0xFFF0 → first mem_addr=0xFFFF0. Ack bytes 0xEA,0x5B,0x00,0xE0 → instr=0xE0005BEA, count=4.
- BUS_BYTES=1, DEPTH=6, no consume, mem_ack after 3 cycles of mem_req each → fills to count=6, then mem_req stays 0. Consume 2 → next fetch address = base+6.
- count=3, consume_n=4 → consume_err pulse, count stays 3, head_ip unchanged. Then consume_n=3 → count=0, instr=0.
- ip_load (ip_new=0x0100) while in REQ with ack pending 2 cycles → mem_req held with the old address until ack. Ack data is absent from the queue. Next mem_addr=(cs<<4)+0x0100.
- cs=0xFFFF, fetch_ip=0xFFFF → mem_addr=0x0FFEF (20-bit wrap). After the ack, fetch_ip=0x0000.
- rst asserted mid-REQ with count=5 → mem_req=0, count=0, instr=0 immediately, without waiting for a clock edge.
